// File: rtl/dtc_cmd_pkg.sv
// Shared types and defaults for the DTC command arbiter.
// Holds the one-hot state encoding, counter widths and the round-robin wrap helper.
package dtc_cmd_pkg;

  localparam int CNT_W = 8;
  localparam int IDX_W = 2;

  localparam logic [CNT_W-1:0] TMO_DEF = 8'd200;
  localparam logic [CNT_W-1:0] GAP_DEF = 8'd4;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_LATCH = 5'b00010,
    ST_ISSUE = 5'b00100,
    ST_DONE  = 5'b01000,
    ST_GAPW  = 5'b10000
  } arb_state_e;

  // Index that sits k places after ptr on a ring of n requesters.
  function automatic logic [IDX_W-1:0] rr_wrap(input logic [IDX_W-1:0] ptr,
                                                input int k, input int n);
    int s;
    s = int'(ptr) + k;
    if (s >= n) s = s - n;
    return s[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/dtc_rr_sel.sv
// Combinational round-robin selector: the first requester after i_ptr wins.
// i_ptr itself has the lowest priority, so the last winner goes to the back of the ring.
module dtc_rr_sel
  import dtc_cmd_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_vld
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    o_idx = '0;
    o_vld = |i_req;
    // Walk from the farthest offset to the nearest so the nearest request overwrites the rest.
    for (int k = NREQ; k >= 1; k--) begin
      if (i_req[rr_wrap(i_ptr, k, NREQ)]) o_idx = rr_wrap(i_ptr, k, NREQ);
    end
  end

endmodule

// File: rtl/dtc_cmd_arb.sv
// Round-robin arbiter that forwards one requester's command at a time to the DTC target,
// with an ack timeout and a fixed idle gap between grants.
module dtc_cmd_arb
  import dtc_cmd_pkg::*;
#(
  parameter int               NREQ = 4,
  parameter logic [CNT_W-1:0] TMO  = TMO_DEF,
  parameter logic [CNT_W-1:0] GAP  = GAP_DEF
) (
  input  logic                 gclk_40m,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_dv,
  input  logic [32*NREQ-1:0]   req_addr,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ack,
  output logic                 udp_cmd_dv,
  output logic [31:0]          udp_cmd_addr,
  output logic [31:0]          udp_cmd_data,
  input  logic                 udp_cmd_dv_ack,
  output logic [1:0]           cmd_src,
  output logic                 tmo_err
);

  arb_state_e       r_state;
  arb_state_e       w_next;
  logic [IDX_W-1:0] r_win;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_src;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_addr;
  logic [31:0]      r_data;

  logic [IDX_W-1:0] w_sel_idx;
  logic             w_sel_vld;
  logic [31:0]      w_win_addr;
  logic [31:0]      w_win_data;

  dtc_rr_sel #(.NREQ(NREQ)) u_rr_sel (
    .i_req (req_dv),
    .i_ptr (r_ptr),
    .o_idx (w_sel_idx),
    .o_vld (w_sel_vld)
  );

  always_comb begin
    w_win_addr = '0;
    w_win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_win == IDX_W'(i)) begin
        w_win_addr = req_addr[32*i +: 32];
        w_win_data = req_data[32*i +: 32];
      end
    end
  end

  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE:  w_next = w_sel_vld ? ST_LATCH : ST_IDLE;
      ST_LATCH: w_next = ST_ISSUE;
      ST_ISSUE: w_next = (udp_cmd_dv_ack || r_cnt == TMO) ? ST_DONE : ST_ISSUE;
      ST_DONE:  w_next = ST_GAPW;
      ST_GAPW:  w_next = (r_cnt >= GAP - 8'd1) ? ST_IDLE : ST_GAPW;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge gclk_40m or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_win   <= '0;
      r_ptr   <= IDX_W'(NREQ - 1);
      r_src   <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state <= w_next;
      case (r_state)
        ST_IDLE: if (w_sel_vld) r_win <= w_sel_idx;
        ST_LATCH: begin
          r_addr <= w_win_addr;
          r_data <= w_win_data;
          r_src  <= r_win;
          r_cnt  <= '0;
        end
        ST_ISSUE: if (r_cnt != '1) r_cnt <= r_cnt + 8'd1;
        ST_DONE: begin
          r_ptr <= r_src;
          r_cnt <= '0;
        end
        ST_GAPW: if (r_cnt != '1) r_cnt <= r_cnt + 8'd1;
        default: r_cnt <= '0;
      endcase
    end
  end

  // Outputs decode straight from the state register, so reset clears them without waiting for a clock.
  always_comb begin
    udp_cmd_dv = (r_state == ST_ISSUE);
    tmo_err    = (r_state == ST_ISSUE) && (r_cnt == TMO) && !udp_cmd_dv_ack;
    for (int i = 0; i < NREQ; i++) begin
      req_ack[i] = (r_state == ST_DONE) && (r_src == IDX_W'(i));
    end
  end

  assign udp_cmd_addr = r_addr;
  assign udp_cmd_data = r_data;
  assign cmd_src      = r_src;

endmodule

// File: tb/tb_dtc_cmd_arb.sv
// Scoreboard bench for dtc_cmd_arb: stimulus queues expected grants, a monitor checks them.
// A responder process models the target ack delay and each requester dropping req_dv on its ack.
module tb_dtc_cmd_arb;

  localparam int          NREQ = 4;
  localparam logic [7:0]  TMO  = 8'd200;
  localparam logic [7:0]  GAP  = 8'd4;

  logic                 gclk_40m = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_dv;
  logic [32*NREQ-1:0]   req_addr;
  logic [32*NREQ-1:0]   req_data;
  logic [NREQ-1:0]      req_ack;
  logic                 udp_cmd_dv;
  logic [31:0]          udp_cmd_addr;
  logic [31:0]          udp_cmd_data;
  logic                 udp_cmd_dv_ack;
  logic [1:0]           cmd_src;
  logic                 tmo_err;

  dtc_cmd_arb #(.NREQ(NREQ), .TMO(TMO), .GAP(GAP)) dut (
    .gclk_40m       (gclk_40m),
    .reset          (reset),
    .req_dv         (req_dv),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .req_ack        (req_ack),
    .udp_cmd_dv     (udp_cmd_dv),
    .udp_cmd_addr   (udp_cmd_addr),
    .udp_cmd_data   (udp_cmd_data),
    .udp_cmd_dv_ack (udp_cmd_dv_ack),
    .cmd_src        (cmd_src),
    .tmo_err        (tmo_err)
  );

  always #12.5 gclk_40m = ~gclk_40m;

  typedef struct {
    logic [1:0]  src;
    logic [31:0] addr;
    logic [31:0] data;
    int          len;   // expected udp_cmd_dv cycles, -1 = not checked
    bit          tmo;
    int          rise;  // expected cycle of udp_cmd_dv rising, -1 = not checked
  } exp_t;

  exp_t            sb_q[$];
  int              n_pass = 0;
  int              n_total = 0;
  int              cyc = 0;
  int              ack_cnt = 0;
  int              tmo_cnt = 0;
  int              exp_acks = 0;
  int              ack_dly = 1;
  logic [NREQ-1:0] stim_dv = '0;
  logic [NREQ-1:0] dropped = '0;
  logic [NREQ-1:0] auto_drop = '1;

  assign req_dv = stim_dv & ~dropped;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  always @(posedge gclk_40m) cyc <= cyc + 1;

  // Target and requester model, updated just after each active edge.
  initial begin
    int  age = 0;
    bit  prev = 1'b0;
    udp_cmd_dv_ack = 1'b0;
    forever begin
      @(posedge gclk_40m);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (!stim_dv[i]) dropped[i] = 1'b0;
        else if (req_ack[i] && auto_drop[i]) dropped[i] = 1'b1;
      end
      if (udp_cmd_dv) age = prev ? age + 1 : 0;
      prev = udp_cmd_dv;
      udp_cmd_dv_ack = udp_cmd_dv && (ack_dly >= 0) && (age == ack_dly);
    end
  end

  // Monitor: pops one expectation per udp_cmd_dv rise, checks on the falling edge of the clock.
  initial begin
    exp_t cur;
    bit   in_cmd = 1'b0;
    bit   prev_dv = 1'b0;
    bit   tmo_seen = 1'b0;
    int   dv_len = 0;
    cur = '{src: 2'd0, addr: 32'd0, data: 32'd0, len: -1, tmo: 1'b0, rise: -1};
    forever begin
      @(negedge gclk_40m);
      if (reset) begin
        in_cmd  = 1'b0;
        prev_dv = 1'b0;
      end else begin
        if (tmo_err) tmo_cnt++;
        if (req_ack != '0) begin
          ack_cnt++;
          check("req_ack_onehot", req_ack, 4'b0001 << cur.src);
        end
        if (udp_cmd_dv && !prev_dv) begin
          check("sb_has_entry", sb_q.size() > 0, 1);
          if (sb_q.size() > 0) begin
            cur = sb_q.pop_front();
            check("grant_src", cmd_src, cur.src);
            check("grant_addr", udp_cmd_addr, cur.addr);
            check("grant_data", udp_cmd_data, cur.data);
            if (cur.rise >= 0) check("dv_latency", cyc, cur.rise);
          end
          in_cmd   = 1'b1;
          dv_len   = 0;
          tmo_seen = 1'b0;
        end
        if (udp_cmd_dv) dv_len++;
        if (tmo_err) tmo_seen = 1'b1;
        if (!udp_cmd_dv && prev_dv && in_cmd) begin
          if (cur.len >= 0) check("dv_length", dv_len, cur.len);
          check("tmo_err_seen", tmo_seen, cur.tmo);
          in_cmd = 1'b0;
        end
        prev_dv = udp_cmd_dv;
      end
    end
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] d);
    req_addr[32*i +: 32] = a;
    req_data[32*i +: 32] = d;
  endtask

  task automatic push(input logic [1:0] src, input int len, input bit tmo, input int rise);
    exp_t e;
    e.src  = src;
    e.addr = req_addr[32*src +: 32];
    e.data = req_data[32*src +: 32];
    e.len  = len;
    e.tmo  = tmo;
    e.rise = rise;
    sb_q.push_back(e);
  endtask

  task automatic wait_acks(input int target, input int budget);
    for (int k = 0; k < budget && ack_cnt < target; k++) @(posedge gclk_40m);
    #1;
    if (ack_cnt < target) check("wait_acks_timeout", ack_cnt, target);
  endtask

  task automatic wait_dv(input int budget);
    for (int k = 0; k < budget && !udp_cmd_dv; k++) begin
      @(posedge gclk_40m);
      #1;
    end
    if (!udp_cmd_dv) check("wait_dv_timeout", udp_cmd_dv, 1);
  endtask

  task automatic settle();
    stim_dv = '0;
    repeat (int'(GAP) + 4) @(posedge gclk_40m);
    #1;
  endtask

  initial begin
    int base;
    reset    = 1'b1;
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < NREQ; i++)
      set_req(i, 32'h1000_0000 + 32'(i) * 32'h100, 32'hA5A5_0000 + 32'(i));
    repeat (3) @(posedge gclk_40m);
    #1;
    check("reset_outputs", {req_ack, udp_cmd_dv, udp_cmd_addr, udp_cmd_data, cmd_src, tmo_err}, '0);
    reset = 1'b0;

    // All four requesters at once: grant order 0,1,2,3.
    ack_dly = 1;
    push(2'd0, 2, 1'b0, cyc + 2);
    push(2'd1, 2, 1'b0, -1);
    push(2'd2, 2, 1'b0, -1);
    push(2'd3, 2, 1'b0, -1);
    stim_dv = 4'b1111;
    exp_acks += 4;
    wait_acks(exp_acks, 200);
    settle();

    // Single request with a 3-cycle target ack.
    ack_dly = 3;
    set_req(0, 32'h0000_0010, 32'hDEAD_BEEF);
    push(2'd0, 4, 1'b0, cyc + 2);
    stim_dv = 4'b0001;
    exp_acks += 1;
    wait_acks(exp_acks, 100);
    check("cmd_src_after_done", cmd_src, 2'd0);
    check("addr_held_after_done", udp_cmd_addr, 32'h0000_0010);
    settle();

    // Target never acks: abandon after TMO+1 cycles of dv.
    ack_dly = -1;
    push(2'd1, int'(TMO) + 1, 1'b1, cyc + 2);
    stim_dv = 4'b0010;
    exp_acks += 1;
    wait_acks(exp_acks, 400);
    settle();

    // Ack lands exactly on the timeout cycle: the ack wins.
    ack_dly = int'(TMO);
    push(2'd2, int'(TMO) + 1, 1'b0, cyc + 2);
    stim_dv = 4'b0100;
    exp_acks += 1;
    wait_acks(exp_acks, 400);
    settle();

    // Fairness: 1 held, 3 arrives during 1's grant, so 3 goes next.
    ack_dly   = 2;
    auto_drop = 4'b1101;
    base      = ack_cnt;
    push(2'd1, 3, 1'b0, cyc + 2);
    push(2'd3, 3, 1'b0, -1);
    push(2'd1, 3, 1'b0, -1);
    stim_dv = 4'b0010;
    wait_dv(20);
    stim_dv[3] = 1'b1;
    wait_acks(base + 2, 100);
    auto_drop = 4'b1111;
    exp_acks += 3;
    wait_acks(exp_acks, 100);
    settle();

    // Reset in the middle of ISSUE: outputs clear at once, no ack for the aborted command.
    ack_dly = -1;
    push(2'd1, -1, 1'b0, cyc + 2);
    stim_dv = 4'b0010;
    wait_dv(20);
    repeat (5) @(posedge gclk_40m);
    #4;
    reset = 1'b1;
    #1;
    check("reset_mid_issue", {req_ack, udp_cmd_dv, udp_cmd_addr, udp_cmd_data, cmd_src, tmo_err}, '0);
    stim_dv = '0;
    repeat (3) @(posedge gclk_40m);
    #1;
    reset   = 1'b0;
    ack_dly = 2;
    push(2'd2, 3, 1'b0, cyc + 2);
    stim_dv = 4'b0100;
    exp_acks += 1;
    wait_acks(exp_acks, 100);
    settle();

    check("scoreboard_drained", sb_q.size(), 0);
    check("total_req_acks", ack_cnt, exp_acks);
    check("total_tmo_err", tmo_cnt, 1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
